// File: rtl/game_sequencer_if.sv
// Frog Rank game-sequencer signal bundle: gameplay inputs in, control/display outputs out.
// All outputs are registered by the sequencer; inputs are levels or one-cycle pulses, no backpressure.
interface game_sequencer_if;
  logic       frame_tick;
  logic       start;
  logic       collision;
  logic       goal;
  logic [2:0] state;
  logic       freeze;
  logic       player_reset;
  logic [4:0] speed_car;
  logic [1:0] lives;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [3:0] led;

  modport master (
    output frame_tick, start, collision, goal,
    input  state, freeze, player_reset, speed_car, lives, score_tens, score_ones, led
  );

  modport slave (
    input  frame_tick, start, collision, goal,
    output state, freeze, player_reset, speed_car, lives, score_tens, score_ones, led
  );
endinterface

// File: rtl/game_sequencer.sv
// Frog Rank game-flow controller: lives, BCD score, car speed, freeze and respawn sequencing.
// Latency 1 cycle from qualifying input to registered outputs; no backpressure, inputs sampled every cycle.
module game_sequencer #(
  parameter int LIVES      = 3,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_STEP = 2,
  parameter int SPEED_MAX  = 31,
  parameter int HIT_FRAMES = 60,
  parameter int LVL_FRAMES = 30
) (
  input  logic              CLK,
  input  logic              RST,
  game_sequencer_if.slave   io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_LVL   = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [4:0] SPD_INIT   = 5'(SPEED_INIT);
  localparam logic [5:0] SPD_STEP   = 6'(SPEED_STEP);
  localparam logic [5:0] SPD_MAX    = 6'(SPEED_MAX);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] LVL_LAST   = 8'(LVL_FRAMES - 1);
  localparam logic [7:0] LOCKOUT    = 8'(HIT_FRAMES);

  state_e     state_q, state_d;
  logic       freeze_q, freeze_d;
  logic       prst_q, prst_d;
  logic       start_q;
  logic [4:0] speed_q, speed_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] led_q, led_d;
  logic [7:0] cnt_q, cnt_d;

  logic       start_edge;
  logic       restart;
  logic [5:0] speed_sum;
  logic [4:0] speed_up;
  logic [3:0] tens_up, ones_up;
  logic [1:0] lives_dn;
  logic [7:0] freeze_last;

  function automatic logic [3:0] led_mask(input logic [1:0] lv, input logic over);
    return {over, lv >= 2'd3, lv >= 2'd2, lv >= 2'd1};
  endfunction

  assign start_edge = io.start & ~start_q;

  // A new game starts from IDLE at once, from GAME_OVER only after the restart lockout.
  assign restart = start_edge &&
                   ((state_q == S_IDLE) || ((state_q == S_OVER) && (cnt_q >= LOCKOUT)));

  assign speed_sum = {1'b0, speed_q} + SPD_STEP;
  assign speed_up  = (speed_sum > SPD_MAX) ? SPD_MAX[4:0] : speed_sum[4:0];
  assign lives_dn  = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
  assign freeze_last = (state_q == S_HIT) ? HIT_LAST : LVL_LAST;

  always_comb begin
    tens_up = tens_q;
    ones_up = ones_q;
    if (!((tens_q == 4'd9) && (ones_q == 4'd9))) begin
      if (ones_q == 4'd9) begin
        ones_up = 4'd0;
        tens_up = tens_q + 4'd1;
      end else begin
        ones_up = ones_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    prst_d  = 1'b0;
    speed_d = speed_q;
    lives_d = lives_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: ;
      S_PLAY: begin
        if (io.collision) begin
          lives_d = lives_dn;
          cnt_d   = 8'd0;
          state_d = (lives_dn == 2'd0) ? S_OVER : S_HIT;
        end else if (io.goal) begin
          tens_d  = tens_up;
          ones_d  = ones_up;
          speed_d = speed_up;
          cnt_d   = 8'd0;
          state_d = S_LVL;
        end
      end
      S_HIT, S_LVL: begin
        if (io.frame_tick) begin
          if (cnt_q == freeze_last) begin
            cnt_d   = 8'd0;
            prst_d  = 1'b1;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_OVER: begin
        if (io.frame_tick && (cnt_q < LOCKOUT)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d = S_PLAY;
      prst_d  = 1'b1;
      lives_d = LIVES_INIT;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      speed_d = SPD_INIT;
      cnt_d   = 8'd0;
    end

    freeze_d = (state_d != S_PLAY);
    led_d    = led_mask(lives_d, state_d == S_OVER);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      freeze_q <= 1'b1;
      prst_q   <= 1'b0;
      start_q  <= 1'b0;
      speed_q  <= SPD_INIT;
      lives_q  <= LIVES_INIT;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      cnt_q    <= 8'd0;
      led_q    <= led_mask(LIVES_INIT, 1'b0);
    end else begin
      state_q  <= state_d;
      freeze_q <= freeze_d;
      prst_q   <= prst_d;
      start_q  <= io.start;
      speed_q  <= speed_d;
      lives_q  <= lives_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
    end
  end

  assign io.state        = state_q;
  assign io.freeze       = freeze_q;
  assign io.player_reset = prst_q;
  assign io.speed_car    = speed_q;
  assign io.lives        = lives_q;
  assign io.score_tens   = tens_q;
  assign io.score_ones   = ones_q;
  assign io.led          = led_q;

endmodule
